reservation_station: RTL

Out-of-order issue buffer for the integer ALU in the Tomasulo core. It accepts decoded instructions from the dispatcher and holds each one until both source operands are known. Operands are captured either at dispatch or by snooping the ALU and load/store common-data broadcasts. Each cycle it issues at most one ready entry to `ArithmeticLogicUnit` over the `rs_*` interface, which is the ALU's input side.

---
 rtl/reservation_station_pkg.sv | 42 ++++
 rtl/rs_priority_select.sv | 20 ++
 rtl/reservation_station.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/reservation_station_pkg.sv
// Shared widths, opcodes and operand-capture helper for the integer ALU reservation station.
package reservation_station_pkg;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] ZERO_WORD = '0;

  localparam int unsigned RS_SIZE_DEFAULT  = 16;
  localparam int unsigned RS_IDX_W_DEFAULT = 4;

  localparam logic [OP_W-1:0] OP_ADD = 6'd1;
  localparam logic [OP_W-1:0] OP_SUB = 6'd2;

  typedef struct packed {
    logic              ready;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] val;
  } operand_t;

  // Capture a pending operand from the common-data buses; the ALU bus wins a tie.
  function automatic operand_t snoop(input operand_t          cur,
                                     input logic              alu_v,
                                     input logic [TAG_W-1:0]  alu_tag,
                                     input logic [WORD_W-1:0] alu_val,
                                     input logic              lsb_v,
                                     input logic [TAG_W-1:0]  lsb_tag,
                                     input logic [WORD_W-1:0] lsb_val);
    operand_t res;
    res = cur;
    if (!cur.ready) begin
      if (alu_v && alu_tag == cur.tag) begin
        res.ready = 1'b1;
        res.val   = alu_val;
      end else if (lsb_v && lsb_tag == cur.tag) begin
        res.ready = 1'b1;
        res.val   = lsb_val;
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/rs_priority_select.sv
// Combinational find-first-set: index of the lowest set bit of req and whether any bit is set.
module rs_priority_select #(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic [SIZE-1:0]  req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (!found && req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reservation_station.sv
// Integer ALU reservation station: holds dispatched instructions until both operands are known,
// snoops the ALU/LSB common-data buses, and issues the lowest-index ready entry each cycle.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned RS_SIZE  = RS_SIZE_DEFAULT,
  parameter int unsigned RS_IDX_W = RS_IDX_W_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              dispatch_signal_in,
  input  logic [OP_W-1:0]   dispatch_op_in,
  input  logic [WORD_W-1:0] dispatch_imm_in,
  input  logic [WORD_W-1:0] dispatch_pc_in,
  input  logic              dispatch_rs1_ready_in,
  input  logic              dispatch_rs2_ready_in,
  input  logic [WORD_W-1:0] dispatch_rs1val_in,
  input  logic [WORD_W-1:0] dispatch_rs2val_in,
  input  logic [TAG_W-1:0]  dispatch_rs1tag_in,
  input  logic [TAG_W-1:0]  dispatch_rs2tag_in,
  input  logic [TAG_W-1:0]  dispatch_dest_in,
  output logic              full_out,
  input  logic              alu_broadcast_signal_in,
  input  logic [WORD_W-1:0] alu_result_in,
  input  logic [TAG_W-1:0]  alu_dest_tag_in,
  input  logic              lsb_broadcast_signal_in,
  input  logic [WORD_W-1:0] lsb_result_in,
  input  logic [TAG_W-1:0]  lsb_dest_tag_in,
  output logic              alu_calculate_signal_out,
  output logic [OP_W-1:0]   alu_op_out,
  output logic [WORD_W-1:0] alu_imm_out,
  output logic [WORD_W-1:0] alu_pc_out,
  output logic [WORD_W-1:0] alu_rs1val_out,
  output logic [WORD_W-1:0] alu_rs2val_out,
  output logic [TAG_W-1:0]  alu_dest_out
);
  logic [RS_SIZE-1:0]  busy_q;
  logic [RS_SIZE-1:0]  busy_next;
  logic [RS_SIZE-1:0]  ready_vec;
  logic [OP_W-1:0]     op_q   [RS_SIZE];
  logic [WORD_W-1:0]   imm_q  [RS_SIZE];
  logic [WORD_W-1:0]   pc_q   [RS_SIZE];
  logic [TAG_W-1:0]    dest_q [RS_SIZE];
  operand_t            vj_q   [RS_SIZE];
  operand_t            vk_q   [RS_SIZE];

  logic [RS_IDX_W-1:0] free_idx;
  logic [RS_IDX_W-1:0] sel_idx;
  logic                free_found;
  logic                sel_found;
  logic                dispatch_fire;
  logic                calc_q;
  operand_t            disp_j;
  operand_t            disp_k;

  assign full_out      = &busy_q;
  assign dispatch_fire = dispatch_signal_in & free_found & ~clear_in;

  // The ALU stalls with the rest of the core, so the issue strobe is masked while disabled.
  assign alu_calculate_signal_out = calc_q & rdy_in;

  always_comb begin
    ready_vec = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy_q[i] & vj_q[i].ready & vk_q[i].ready;
    end
  end

  rs_priority_select #(.SIZE(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_select (
    .req   (~busy_q),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_priority_select #(.SIZE(RS_SIZE), .IDX_W(RS_IDX_W)) u_issue_select (
    .req   (ready_vec),
    .idx   (sel_idx),
    .found (sel_found)
  );

  always_comb begin
    disp_j = snoop({dispatch_rs1_ready_in, dispatch_rs1tag_in, dispatch_rs1val_in},
                   alu_broadcast_signal_in, alu_dest_tag_in, alu_result_in,
                   lsb_broadcast_signal_in, lsb_dest_tag_in, lsb_result_in);
    disp_k = snoop({dispatch_rs2_ready_in, dispatch_rs2tag_in, dispatch_rs2val_in},
                   alu_broadcast_signal_in, alu_dest_tag_in, alu_result_in,
                   lsb_broadcast_signal_in, lsb_dest_tag_in, lsb_result_in);
  end

  // The free slot is never the issuing slot, so both updates can apply in one cycle.
  always_comb begin
    busy_next = busy_q;
    if (sel_found) busy_next[sel_idx] = 1'b0;
    if (dispatch_fire) busy_next[free_idx] = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q         <= '0;
      calc_q         <= 1'b0;
      alu_op_out     <= '0;
      alu_imm_out    <= ZERO_WORD;
      alu_pc_out     <= ZERO_WORD;
      alu_rs1val_out <= ZERO_WORD;
      alu_rs2val_out <= ZERO_WORD;
      alu_dest_out   <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        busy_q <= '0;
        calc_q <= 1'b0;
      end else begin
        busy_q <= busy_next;
        calc_q <= sel_found;
        if (sel_found) begin
          alu_op_out     <= op_q[sel_idx];
          alu_imm_out    <= imm_q[sel_idx];
          alu_pc_out     <= pc_q[sel_idx];
          alu_rs1val_out <= vj_q[sel_idx].val;
          alu_rs2val_out <= vk_q[sel_idx].val;
          alu_dest_out   <= dest_q[sel_idx];
        end
      end
    end
  end

  // Entry payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !clear_in) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (dispatch_fire && free_idx == RS_IDX_W'(i)) begin
          op_q[i]   <= dispatch_op_in;
          imm_q[i]  <= dispatch_imm_in;
          pc_q[i]   <= dispatch_pc_in;
          dest_q[i] <= dispatch_dest_in;
          vj_q[i]   <= disp_j;
          vk_q[i]   <= disp_k;
        end else if (busy_q[i]) begin
          vj_q[i] <= snoop(vj_q[i], alu_broadcast_signal_in, alu_dest_tag_in, alu_result_in,
                           lsb_broadcast_signal_in, lsb_dest_tag_in, lsb_result_in);
          vk_q[i] <= snoop(vk_q[i], alu_broadcast_signal_in, alu_dest_tag_in, alu_result_in,
                           lsb_broadcast_signal_in, lsb_dest_tag_in, lsb_result_in);
        end
      end
    end
  end
endmodule
